// File: rtl/rv_inst_encoder_pkg.sv
// Shared RV32I field layouts, opcode/funct3 constants and command op encoding.
// Used by the encoder and the decoders, so both sides agree on the bit positions.
package rv_inst_encoder_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  typedef enum logic [2:0] {
    OP_ADDI = 3'd0,
    OP_LW   = 3'd1,
    OP_SW   = 3'd2,
    OP_LUI  = 3'd3,
    OP_JALR = 3'd4
  } cmd_op_t;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_type_t;

  typedef struct packed {
    logic [6:0]  imm_hi;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  imm_lo;
    logic [6:0]  opcode;
  } s_type_t;

  typedef struct packed {
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } u_type_t;

  typedef struct packed {
    logic        err;
    logic        last;
    logic [31:0] inst;
  } out_word_t;

  // True when v is the sign extension of a 12-bit value.
  function automatic logic fits_simm12(input logic [31:0] v);
    return (&v[31:11]) | (~|v[31:11]);
  endfunction

endpackage

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO, WIDTH x DEPTH. Data is visible at the head one cycle after push, with no bypass.
// Backpressure: full_o blocks pushes; pop_dat_o reads as zero while empty.
module rv_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/rv_inst_encoder.sv
// Encodes commands into RV32I words through an output FIFO; first word appears the cycle after accept.
// cmd_rdy drops while the FIFO is full or a low word is pending; RVB_LI_EXPAND_EN enables LUI+ADDI li expansion.
module rv_inst_encoder
  import rv_inst_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [2:0]  cmd_op,
  input  logic [4:0]  cmd_rd,
  input  logic [4:0]  cmd_rs1,
  input  logic [4:0]  cmd_rs2,
  input  logic [31:0] cmd_imm,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic        out_last
);

  localparam out_word_t ERR_WORD = '{err: 1'b1, last: 1'b1, inst: 32'h0};

  cmd_op_t   op;
  logic      imm_ok;
  logic      enc_err;
  logic      cmd_acc;
  logic      in_idle;
  logic      fifo_full, fifo_empty;
  logic      push_vld;
  i_type_t   i_w;
  s_type_t   s_w;
  u_type_t   u_w;
  logic [31:0] enc;
  out_word_t word0;
  out_word_t push_dat;
  out_word_t head;

  assign op      = cmd_op_t'(cmd_op);
  assign imm_ok  = fits_simm12(cmd_imm);
  assign cmd_rdy = !rst && in_idle && !fifo_full;
  assign cmd_acc = cmd_vld && cmd_rdy;

  always_comb begin
    i_w     = '{imm: cmd_imm[11:0], rs1: cmd_rs1, funct3: F3_ADDI, rd: cmd_rd, opcode: OPC_OP_IMM};
    s_w     = '{imm_hi: cmd_imm[11:5], rs2: cmd_rs2, rs1: cmd_rs1, funct3: F3_SW,
                imm_lo: cmd_imm[4:0], opcode: OPC_STORE};
    u_w     = '{imm: cmd_imm[31:12], rd: cmd_rd, opcode: OPC_LUI};
    enc     = '0;
    enc_err = 1'b1;
    case (op)
      OP_ADDI: begin
        enc     = i_w;
        enc_err = !imm_ok;
      end
      OP_LW: begin
        i_w.funct3 = F3_LW;
        i_w.opcode = OPC_LOAD;
        enc        = i_w;
        enc_err    = !imm_ok;
      end
      OP_JALR: begin
        i_w.funct3 = F3_JALR;
        i_w.opcode = OPC_JALR;
        enc        = i_w;
        enc_err    = !imm_ok;
      end
      OP_SW: begin
        enc     = s_w;
        enc_err = !imm_ok;
      end
      OP_LUI: begin
        enc     = u_w;
        enc_err = (cmd_imm[11:0] != 12'h0);
      end
      default: begin
        enc     = '0;
        enc_err = 1'b1;
      end
    endcase
  end

`ifdef RVB_LI_EXPAND_EN
  typedef enum logic {S_IDLE, S_EMIT_LO} state_t;

  state_t      state_q;
  logic [31:0] lo_q, lo_d;
  logic [31:0] li_hi;
  logic        expand;
  u_type_t     hi_w;

  // Rounding the upper part compensates for the sign-extended ADDI low half.
  assign li_hi  = cmd_imm + 32'h800;
  assign expand = (op == OP_ADDI) && !imm_ok && (cmd_rs1 == 5'd0);
  assign hi_w   = '{imm: li_hi[31:12], rd: cmd_rd, opcode: OPC_LUI};
  assign lo_d   = i_type_t'('{imm: cmd_imm[11:0], rs1: cmd_rd, funct3: F3_ADDI,
                             rd: cmd_rd, opcode: OPC_OP_IMM});
  assign in_idle = (state_q == S_IDLE);

  always_comb begin
    word0 = enc_err ? ERR_WORD : '{err: 1'b0, last: 1'b1, inst: enc};
    if (expand) word0 = '{err: 1'b0, last: 1'b0, inst: hi_w};
  end

  assign push_vld = in_idle ? cmd_acc : !fifo_full;
  assign push_dat = in_idle ? word0 : '{err: 1'b0, last: 1'b1, inst: lo_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_acc && expand) begin
            lo_q    <= lo_d;
            state_q <= S_EMIT_LO;
          end
        end
        S_EMIT_LO: begin
          if (!fifo_full) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`else
  assign in_idle  = 1'b1;
  assign word0    = enc_err ? ERR_WORD : '{err: 1'b0, last: 1'b1, inst: enc};
  assign push_vld = cmd_acc;
  assign push_dat = word0;
`endif

  rv_sync_fifo #(
    .WIDTH ($bits(out_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push_vld),
    .push_dat_i (push_dat),
    .pop_i      (out_rdy),
    .pop_dat_o  (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign out_vld  = !fifo_empty;
  assign out_inst = head.inst;
  assign out_err  = head.err;
  assign out_last = head.last;

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Bench for rv_inst_encoder: directed test-plan words plus randomized commands against an arithmetic model.
// Build with or without RVB_LI_EXPAND_EN; expectations follow the same define.
module tb_rv_inst_encoder;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [31:0] cmd_imm;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_inst;
  logic        out_err;
  logic        out_last;

  int          total = 0;
  int          bad   = 0;
  logic [33:0] expq[$];
  bit          acc;
  bit          popped;
  bit          rand_rdy = 1'b0;

  rv_inst_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .cmd_op   (cmd_op),
    .cmd_rd   (cmd_rd),
    .cmd_rs1  (cmd_rs1),
    .cmd_rs2  (cmd_rs2),
    .cmd_imm  (cmd_imm),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_inst (out_inst),
    .out_err  (out_err),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: words built from field positions with shifts and masks.
  function automatic void model_push(input logic [2:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [31:0] imm);
    logic [31:0] r, s1, s2, hi;
    int          sv;
    bit          fits;
    r    = {27'b0, rd};
    s1   = {27'b0, rs1};
    s2   = {27'b0, rs2};
    sv   = $signed(imm);
    fits = (sv >= -2048) && (sv <= 2047);
    case (op)
      3'd0, 3'd1, 3'd4: begin
        if (fits) begin
          logic [31:0] f3, opc;
          f3  = (op == 3'd1) ? 32'd2 : 32'd0;
          opc = (op == 3'd0) ? 32'h13 : (op == 3'd1) ? 32'h03 : 32'h67;
          expq.push_back({2'b01, ((imm & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (r << 7) | opc});
        end
`ifdef RVB_LI_EXPAND_EN
        else if (op == 3'd0 && rs1 == 5'd0) begin
          hi = imm + 32'h800;
          expq.push_back({2'b00, (hi & 32'hFFFFF000) | (r << 7) | 32'h37});
          expq.push_back({2'b01, ((imm & 32'hFFF) << 20) | (r << 15) | (r << 7) | 32'h13});
        end
`endif
        else expq.push_back({2'b11, 32'h0});
      end
      3'd2: begin
        if (fits)
          expq.push_back({2'b01, (((imm >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) |
                                 (32'd2 << 12) | ((imm & 32'h1F) << 7) | 32'h23});
        else expq.push_back({2'b11, 32'h0});
      end
      3'd3: begin
        if ((imm & 32'hFFF) == 0) expq.push_back({2'b01, imm | (r << 7) | 32'h37});
        else expq.push_back({2'b11, 32'h0});
      end
      default: expq.push_back({2'b11, 32'h0});
    endcase
  endfunction

  // One clock: observe at negedge, transfers happen at posedge, drive #1 later.
  task automatic tick();
    logic [33:0] e;
    @(negedge clk);
    acc    = cmd_vld && cmd_rdy;
    popped = out_vld && out_rdy;
    if (acc) model_push(cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm);
    if (popped) begin
      if (expq.size() == 0) chk("spurious_word", {out_err, out_last, out_inst}, 34'h3_FFFF_FFFF);
      else begin
        e = expq.pop_front();
        chk("word", {out_err, out_last, out_inst}, e);
      end
    end
    @(posedge clk);
    #1;
    if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int n;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_vld = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      tick();
      n++;
    end
    chk("accept", 34'(acc), 34'd1);
    cmd_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_empty", 34'(expq.size()), 34'd0);
  endtask

  task automatic rand_cmd();
    logic [31:0] imm;
    case ($urandom_range(0, 3))
      0: imm = 32'($signed($urandom_range(0, 4095)) - 2048);
      1: imm = $urandom();
      2: imm = $urandom() & 32'hFFFFF000;
      default: begin
        case ($urandom_range(0, 5))
          0: imm = 32'd2047;
          1: imm = 32'hFFFFF800;
          2: imm = 32'd2048;
          3: imm = 32'hFFFFF7FF;
          4: imm = 32'h7FFFF800;
          default: imm = 32'h12345FFF;
        endcase
      end
    endcase
    cmd_op  = 3'($urandom_range(0, 7));
    cmd_rd  = 5'($urandom_range(0, 31));
    cmd_rs1 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    cmd_rs2 = 5'($urandom_range(0, 31));
    cmd_imm = imm;
  endtask

  initial begin
    int nacc;
    bit pp_seen;
    rst = 1'b1; cmd_vld = 1'b0; out_rdy = 1'b1;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", 34'(out_vld), 34'd0);
    chk("rst_word", {out_err, out_last, out_inst}, 34'd0);
    chk("rst_cmd_rdy", 34'(cmd_rdy), 34'd0);
    rst = 1'b0;
    #1;
    chk("idle_cmd_rdy", 34'(cmd_rdy), 34'd1);

    // Directed encodings, head checked right after the accepting edge.
    send(3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    chk("addi_vld", 34'(out_vld), 34'd1);
    chk("addi_word", {out_err, out_last, out_inst}, {2'b01, 32'h00500093});
    drain();
    send(3'd1, 5'd2, 5'd3, 5'd0, 32'd8);
    chk("lw_word", {out_err, out_last, out_inst}, {2'b01, 32'h0081A103});
    drain();
    send(3'd2, 5'd0, 5'd6, 5'd5, 32'hFFFFFFFC);
    chk("sw_word", {out_err, out_last, out_inst}, {2'b01, 32'hFE532E23});
    drain();
    send(3'd3, 5'd1, 5'd0, 5'd0, 32'h12345001);
    chk("lui_err", {out_err, out_last, out_inst}, {2'b11, 32'h0});
    drain();
    send(3'd6, 5'd1, 5'd1, 5'd1, 32'd0);
    chk("op6_err", {out_err, out_last, out_inst}, {2'b11, 32'h0});
    drain();
    send(3'd0, 5'd1, 5'd0, 5'd0, 32'd2047);
    chk("addi_2047", {out_err, out_last, out_inst}, {2'b01, 32'h7FF00093});
    drain();
    send(3'd0, 5'd1, 5'd4, 5'd0, 32'd2048);
    chk("addi_2048_rs1", {out_err, out_last, out_inst}, {2'b11, 32'h0});
    drain();

    send(3'd0, 5'd1, 5'd0, 5'd0, 32'h12345678);
`ifdef RVB_LI_EXPAND_EN
    chk("li_hi", {out_err, out_last, out_inst}, {2'b00, 32'h123450B7});
    tick();
    chk("li_lo", {out_err, out_last, out_inst}, {2'b01, 32'h67808093});
`else
    chk("li_err", {out_err, out_last, out_inst}, {2'b11, 32'h0});
    tick();
    chk("li_single", 34'(out_vld), 34'd0);
`endif
    drain();
    send(3'd0, 5'd1, 5'd0, 5'd0, 32'h12345FFF);
`ifdef RVB_LI_EXPAND_EN
    chk("li2_hi", {out_err, out_last, out_inst}, {2'b00, 32'h123460B7});
    tick();
    chk("li2_lo", {out_err, out_last, out_inst}, {2'b01, 32'hFFF08093});
`else
    chk("li2_err", {out_err, out_last, out_inst}, {2'b11, 32'h0});
`endif
    drain();

    // Backpressure: fill, hold, then release with cmd_vld still high.
    out_rdy = 1'b0;
    nacc = 0;
    pp_seen = 1'b0;
    cmd_op = 3'd0; cmd_rd = 5'd3; cmd_rs1 = 5'd4; cmd_rs2 = 5'd0; cmd_imm = 32'd17;
    cmd_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (acc) begin
        nacc++;
        cmd_rd = 5'($urandom_range(0, 31));
        cmd_imm = 32'($urandom_range(0, 2047));
      end
    end
    chk("fill_count", 34'(nacc), 34'(DEPTH));
    chk("full_cmd_rdy", 34'(cmd_rdy), 34'd0);
    chk("stall_head", {out_err, out_last, out_inst}, expq[0]);
    out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (acc && popped) pp_seen = 1'b1;
      if (acc) cmd_imm = 32'($urandom_range(0, 2047));
    end
    cmd_vld = 1'b0;
    chk("push_pop_same", 34'(pp_seen), 34'd1);
    drain();

    // Randomized traffic with random consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_cmd();
      send(cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm);
    end
    out_rdy = 1'b1;
    rand_rdy = 1'b0;
    drain();

    // Reset with a full FIFO and, when expanding, a pending low word.
    out_rdy = 1'b0;
    send(3'd0, 5'd5, 5'd0, 5'd0, 32'd1);
    send(3'd0, 5'd1, 5'd0, 5'd0, 32'h12345678);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_out_vld", 34'(out_vld), 34'd0);
    chk("midrst_cmd_rdy", 34'(cmd_rdy), 34'd0);
    expq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_rdy = 1'b1;
    send(3'd0, 5'd2, 5'd0, 5'd0, 32'd7);
    chk("post_rst_word", {out_err, out_last, out_inst}, {2'b01, 32'h00700113});
    drain();
    repeat (3) tick();
    chk("post_rst_idle", 34'(out_vld), 34'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
